match_event_logger: RTL and testbench

//  Downstream stage of the serial pattern detector: consumes its 1-bit match output and logs
//  the bit index of every detected match into a small FIFO for a consumer to drain.

---
 rtl/match_event_logger.sv | 136 +++++++++++++
 tb/tb_match_event_logger.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/match_event_logger.sv
// ----------------------------------------------------------------------------
// match_event_logger
//
// Purpose:
//   Sits behind the serial pattern detector. Every qualified serial bit gets
//   an index from a free-running counter. When the detector flags a match on
//   a qualified bit, the index of that bit is pushed into a small show-ahead
//   FIFO for a host to drain. A saturating match counter and a sticky overflow
//   flag report how many matches were seen and whether any were lost.
//
// Parameters:
//   IDX_W  width of the bit index and of each logged entry
//   DEPTH  FIFO entries (power of two, at least 2)
//   CNT_W  width of the saturating match counter
//
// Ports:
//   clk          rising-edge clock shared with the detector
//   rst_n        asynchronous active-low reset
//   bit_valid    qualifies the current serial bit
//   match_in     detector output, only looked at when bit_valid is high
//   clear        synchronous flush of FIFO, index, counter and overflow
//   rd_valid     FIFO head is valid
//   rd_data      bit index held at the FIFO head
//   rd_ready     consumer takes the head when rd_valid and rd_ready are high
//   level        number of entries held
//   match_count  matches seen, saturating at all-ones
//   overflow     sticky flag: a match was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module match_event_logger #(
    parameter int IDX_W = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             match_in,
    input  logic             clear,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_data,
    input  logic             rd_ready,
    output logic [LVL_W-1:0] level,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] bit_idx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             match_ev;
    logic             pop;
    logic             full;
    logic             do_write;
    logic [LVL_W-1:0] remaining;
    logic [LVL_W-1:0] level_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [IDX_W-1:0] head_next;

    // Next-state decode for the FIFO. A push into a full FIFO is only
    // accepted when the head leaves in the same cycle, because the popped
    // slot is exactly the one the write pointer points at. The registered
    // head for the next cycle is either the incoming index (when no older
    // entry survives this cycle) or the stored entry at the new read pointer.
    always_comb begin
        match_ev    = bit_valid & match_in;
        pop         = rd_valid & rd_ready;
        full        = (level == LVL_FULL);
        do_write    = match_ev & (~full | pop);
        remaining   = pop ? (level - LVL_ONE) : level;
        level_next  = do_write ? (remaining + LVL_ONE) : remaining;
        rd_ptr_next = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
        head_next   = (remaining == '0) ? bit_idx : mem[rd_ptr_next];
    end

    // Storage array. It carries no reset; validity comes from level and the
    // pointers, so stale contents are never presented to the consumer.
    always_ff @(posedge clk) begin
        if (!clear && do_write) begin
            mem[wr_ptr] <= bit_idx;
        end
    end

    // Control and status registers. clear takes priority over any push or
    // pop in the same cycle. rd_data is only reloaded when there will be an
    // entry to show, so it holds its last value while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            bit_idx     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rd_valid    <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (bit_valid) begin
                bit_idx <= bit_idx + IDX_ONE;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr   <= rd_ptr_next;
            level    <= level_next;
            rd_valid <= (level_next != '0);
            if (level_next != '0) begin
                rd_data <= head_next;
            end
            if (match_ev && (match_count != '1)) begin
                match_count <= match_count + CNT_ONE;
            end
            if (match_ev && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_match_event_logger.sv
// ----------------------------------------------------------------------------
// tb_match_event_logger
//
// Directed bench for match_event_logger. A default-sized instance covers the
// FIFO behaviour; a narrow instance (4-bit index, 3-bit counter) shares the
// same inputs and is used for index wrap and counter saturation.
// ----------------------------------------------------------------------------
module tb_match_event_logger;

    logic        clk;
    logic        rst_n;
    logic        bit_valid;
    logic        match_in;
    logic        clear;
    logic        rd_ready;

    logic        rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  level;
    logic [15:0] match_count;
    logic        overflow;

    logic        s_rd_valid;
    logic [3:0]  s_rd_data;
    logic [2:0]  s_level;
    logic [2:0]  s_match_count;
    logic        s_overflow;

    int nAsserts = 0;
    int nFails   = 0;

    match_event_logger #(.IDX_W(16), .DEPTH(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid),
        .match_in    (match_in),
        .clear       (clear),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .level       (level),
        .match_count (match_count),
        .overflow    (overflow)
    );

    match_event_logger #(.IDX_W(4), .DEPTH(4), .CNT_W(3)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid),
        .match_in    (match_in),
        .clear       (clear),
        .rd_valid    (s_rd_valid),
        .rd_data     (s_rd_data),
        .rd_ready    (rd_ready),
        .level       (s_level),
        .match_count (s_match_count),
        .overflow    (s_overflow)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then wait past the edge so outputs settle.
    task automatic applyStimulus(input logic bv, input logic mi,
                                 input logic rr, input logic clr);
        bit_valid = bv;
        match_in  = mi;
        rd_ready  = rr;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    // One immediate-assertion comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        match_in  = 1'b0;
        clear     = 1'b0;
        rd_ready  = 1'b0;

        // Reset held for three clocks with random traffic.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_count", 32'(match_count), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;

        // Matches at bits 3 and 7, consumer always ready.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, (k == 3) || (k == 7), 1'b1, 1'b0);
            checkOutput($sformatf("basic_valid_%0d", k), 32'(rd_valid),
                        32'((k == 3) || (k == 7)));
            if (rd_valid) begin
                checkOutput($sformatf("basic_data_%0d", k), 32'(rd_data), 32'(k));
            end
        end
        checkOutput("basic_count", 32'(match_count), 2);

        // Nine matches into an 8-deep FIFO with no reads.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("ovf_level", 32'(level), 8);
        checkOutput("ovf_flag", 32'(overflow), 1);
        checkOutput("ovf_count", 32'(match_count), 9);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ovf_drain_valid_%0d", i), 32'(rd_valid), 1);
            checkOutput($sformatf("ovf_drain_data_%0d", i), 32'(rd_data), 32'(i));
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ovf_empty_valid", 32'(rd_valid), 0);
        checkOutput("ovf_empty_level", 32'(level), 0);
        checkOutput("ovf_sticky", 32'(overflow), 1);

        // Fill exactly, then push and pop in the same cycle.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_overflow", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("full_level", 32'(level), 8);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("pp_level", 32'(level), 8);
        checkOutput("pp_overflow", 32'(overflow), 0);
        checkOutput("pp_head", 32'(rd_data), 1);
        checkOutput("pp_count", 32'(match_count), 9);
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("pp_drain_data_%0d", i), 32'(rd_data), 32'(i));
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("pp_drained", 32'(level), 0);

        // Unqualified match ignored; index wrap on the narrow instance.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("nq_level", 32'(level), 0);
        checkOutput("nq_count", 32'(match_count), 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_small_level", 32'(s_level), 1);
        checkOutput("wrap_small_data", 32'(s_rd_data), 0);
        checkOutput("wrap_main_data", 32'(rd_data), 16);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("sat_small_count", 32'(s_match_count), 7);
        checkOutput("sat_main_count", 32'(match_count), 9);

        // clear colliding with a match while three entries are held.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("pre_clr_level", 32'(level), 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_level", 32'(level), 0);
        checkOutput("clr_count", 32'(match_count), 0);
        checkOutput("clr_valid", 32'(rd_valid), 0);

        // Asynchronous reset pulse between clock edges.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_arst_level", 32'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(rd_valid), 0);
        checkOutput("arst_level", 32'(level), 0);
        checkOutput("arst_count", 32'(match_count), 0);
        checkOutput("arst_data", 32'(rd_data), 0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("post_arst_level", 32'(level), 1);
        checkOutput("post_arst_count", 32'(match_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
